// File: rtl/mips_pipe_pkg.sv
// Shared types for the hazard scoreboard: the per-stage track entry and the
// result-availability encodings used to decide forward-versus-stall.
package mips_pipe_pkg;

  localparam int MAX_REG_AW = 8;
  localparam int AVAIL_W    = 8;
  localparam int FWD_REGFILE = 0;

  localparam logic [AVAIL_W-1:0] AVAIL_ALU = AVAIL_W'(1);

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dest;
    logic                  wr;
    logic [AVAIL_W-1:0]    avail;
  } trk_entry_t;

  // A load result is forwardable only LOAD_LAT registers later than an ALU result.
  function automatic logic [AVAIL_W-1:0] avail_for(input logic is_load, input int load_lat);
    return is_load ? AVAIL_W'(1 + load_lat) : AVAIL_ALU;
  endfunction

endpackage

// File: rtl/mips_operand_hazard_check.sv
// One operand's view of the in-flight writers: picks the youngest matching
// writer and decides whether its result can be forwarded yet or ID must stall.
module mips_operand_hazard_check
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int FSEL_W = 2
) (
  input  trk_entry_t [DEPTH-1:0] trk_i,
  input  logic [MAX_REG_AW-1:0]  addr_i,
  input  logic                   enable_i,
  output logic [FSEL_W-1:0]      sel_o,
  output logic                   hazard_o
);

  logic               found;
  logic [AVAIL_W-1:0] hitDist;
  logic [AVAIL_W-1:0] hitAvail;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    found    = 1'b0;
    hitDist  = '0;
    hitAvail = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (trk_i[j].valid && trk_i[j].wr && (trk_i[j].dest == addr_i)) begin
        found    = 1'b1;
        hitDist  = AVAIL_W'(j + 1);
        hitAvail = trk_i[j].avail;
      end
    end
    hazard_o = enable_i && found && (hitDist < hitAvail);
    sel_o    = (enable_i && found && !hazard_o) ? FSEL_W'(hitDist) : FSEL_W'(FWD_REGFILE);
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Depth-parametrised hazard/forwarding scoreboard beside ID: tracks in-flight
// writers, raises stall / IF-ID flush and registers per-operand forward selects for EX.
module mips_hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter  int DEPTH    = 3,
  parameter  int REG_AW   = 5,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 32,
  localparam int FSEL_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_reg_write_i,
  input  logic              id_is_load_i,
  input  logic              id_redirect_i,
  output logic              stall_o,
  output logic              if_id_flush_o,
  output logic [FSEL_W-1:0] ex_fwd_a_o,
  output logic [FSEL_W-1:0] ex_fwd_b_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  trk_entry_t [DEPTH-1:0] trk_q, trk_d;
  trk_entry_t             idEntry;
  logic [FSEL_W-1:0]      ex_fwd_a_q, ex_fwd_a_d, ex_fwd_b_q, ex_fwd_b_d;
  logic [CNT_W-1:0]       stall_count_q, stall_count_d;
  logic [FSEL_W-1:0]      selRs, selRt;
  logic                   hazardRs, hazardRt;
  logic                   enableRs, enableRt;
  logic                   stall, issue;

  assign enableRs = id_valid_i && id_use_rs_i && (id_rs_i != '0);
  assign enableRt = id_valid_i && id_use_rt_i && (id_rt_i != '0);

  mips_operand_hazard_check #(.DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_check_rs (
    .trk_i    (trk_q),
    .addr_i   (MAX_REG_AW'(id_rs_i)),
    .enable_i (enableRs),
    .sel_o    (selRs),
    .hazard_o (hazardRs)
  );

  mips_operand_hazard_check #(.DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_check_rt (
    .trk_i    (trk_q),
    .addr_i   (MAX_REG_AW'(id_rt_i)),
    .enable_i (enableRt),
    .sel_o    (selRt),
    .hazard_o (hazardRt)
  );

  // Stall beats redirect so a branch waiting on its operands is not squashed early.
  assign stall         = reset_i && (hazardRs || hazardRt);
  assign issue         = id_valid_i && !stall;
  assign stall_o       = stall;
  assign if_id_flush_o = reset_i && id_redirect_i && !stall;

  assign idEntry = '{valid: 1'b1,
                     dest:  MAX_REG_AW'(id_dest_i),
                     wr:    id_reg_write_i,
                     avail: avail_for(id_is_load_i, LOAD_LAT)};

  always_comb begin
    trk_d[0] = issue ? idEntry : '0;
    for (int k = 1; k < DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end
    ex_fwd_a_d    = issue ? selRs : '0;
    ex_fwd_b_d    = issue ? selRt : '0;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      trk_q         <= '0;
      ex_fwd_a_q    <= '0;
      ex_fwd_b_q    <= '0;
      stall_count_q <= '0;
    end else begin
      trk_q         <= trk_d;
      ex_fwd_a_q    <= ex_fwd_a_d;
      ex_fwd_b_q    <= ex_fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_fwd_a_o    = ex_fwd_a_q;
  assign ex_fwd_b_o    = ex_fwd_b_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Bench for mips_hazard_scoreboard: hand-derived instruction tables for a LOAD_LAT=1
// instance and a LOAD_LAT=2 / 2-bit-counter instance sharing the same ID inputs.
module tb_mips_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int FSEL_W = 2;

  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              useRs;
    logic              useRt;
    logic [REG_AW-1:0] dest;
    logic              regWr;
    logic              isLoad;
    logic              redirect;
    logic              expStall;
    logic              expFlush;
    logic [FSEL_W-1:0] expFwdA;
    logic [FSEL_W-1:0] expFwdB;
  } vec_t;

  typedef struct {
    logic [FSEL_W-1:0] fwdA;
    logic [FSEL_W-1:0] fwdB;
    string             tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              resetN;
  logic              idValid, idUseRs, idUseRt, idRegWrite, idIsLoad, idRedirect;
  logic [REG_AW-1:0] idRs, idRt, idDest;
  logic              stall1, flush1, stall2, flush2;
  logic [FSEL_W-1:0] fwdA1, fwdB1, fwdA2, fwdB2;
  logic [31:0]       count1;
  logic [1:0]        count2;

  int   compared   = 0;
  int   mismatched = 0;
  bit   dut2Sel    = 1'b0;
  vec_t mainVecs[$];
  vec_t lat2Vecs[$];
  exp_t expQ[$];

  always #5 clk = ~clk;

  mips_hazard_scoreboard #(.DEPTH(3), .REG_AW(REG_AW), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk_i          (clk),
    .reset_i        (resetN),
    .id_valid_i     (idValid),
    .id_rs_i        (idRs),
    .id_rt_i        (idRt),
    .id_use_rs_i    (idUseRs),
    .id_use_rt_i    (idUseRt),
    .id_dest_i      (idDest),
    .id_reg_write_i (idRegWrite),
    .id_is_load_i   (idIsLoad),
    .id_redirect_i  (idRedirect),
    .stall_o        (stall1),
    .if_id_flush_o  (flush1),
    .ex_fwd_a_o     (fwdA1),
    .ex_fwd_b_o     (fwdB1),
    .stall_count_o  (count1)
  );

  mips_hazard_scoreboard #(.DEPTH(3), .REG_AW(REG_AW), .LOAD_LAT(2), .CNT_W(2)) dut2 (
    .clk_i          (clk),
    .reset_i        (resetN),
    .id_valid_i     (idValid),
    .id_rs_i        (idRs),
    .id_rt_i        (idRt),
    .id_use_rs_i    (idUseRs),
    .id_use_rt_i    (idUseRt),
    .id_dest_i      (idDest),
    .id_reg_write_i (idRegWrite),
    .id_is_load_i   (idIsLoad),
    .id_redirect_i  (idRedirect),
    .stall_o        (stall2),
    .if_id_flush_o  (flush2),
    .ex_fwd_a_o     (fwdA2),
    .ex_fwd_b_o     (fwdB2),
    .stall_count_o  (count2)
  );

  function automatic vec_t mkVec(input logic valid, input int rs, input int rt,
                                 input logic useRs, input logic useRt, input int dest,
                                 input logic regWr, input logic isLoad, input logic redirect,
                                 input logic expStall, input logic expFlush,
                                 input int expA, input int expB);
    vec_t v;
    v.valid    = valid;
    v.rs       = REG_AW'(rs);
    v.rt       = REG_AW'(rt);
    v.useRs    = useRs;
    v.useRt    = useRt;
    v.dest     = REG_AW'(dest);
    v.regWr    = regWr;
    v.isLoad   = isLoad;
    v.redirect = redirect;
    v.expStall = expStall;
    v.expFlush = expFlush;
    v.expFwdA  = FSEL_W'(expA);
    v.expFwdB  = FSEL_W'(expB);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    idValid    = v.valid;
    idRs       = v.rs;
    idRt       = v.rt;
    idUseRs    = v.useRs;
    idUseRt    = v.useRt;
    idDest     = v.dest;
    idRegWrite = v.regWr;
    idIsLoad   = v.isLoad;
    idRedirect = v.redirect;
  endtask

  // Stall/flush are checked in the ID cycle; forward selects are queued and checked in EX.
  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    driveInputs(v);
    #1;
    checkOutput({tag, ".stall"}, 32'(dut2Sel ? stall2 : stall1), 32'(v.expStall));
    checkOutput({tag, ".flush"}, 32'(dut2Sel ? flush2 : flush1), 32'(v.expFlush));
    e.fwdA = v.expFwdA;
    e.fwdB = v.expFwdB;
    e.tag  = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput({e.tag, ".fwdA"}, 32'(dut2Sel ? fwdA2 : fwdA1), 32'(e.fwdA));
    checkOutput({e.tag, ".fwdB"}, 32'(dut2Sel ? fwdB2 : fwdB1), 32'(e.fwdB));
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    driveInputs(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // valid rs rt useRs useRt dest wr load redir | stall flush fwdA fwdB
    mainVecs.push_back(mkVec(1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0)); // add r3
    mainVecs.push_back(mkVec(1,  3,  3, 1, 1,  4, 1, 0, 0, 0, 0, 1, 1)); // add r4,r3,r3
    mainVecs.push_back(mkVec(1,  1,  0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 0)); // lw r5
    mainVecs.push_back(mkVec(1,  5,  1, 1, 1,  6, 1, 0, 0, 1, 0, 0, 0)); // sub r6,r5,r1 stalls
    mainVecs.push_back(mkVec(1,  5,  1, 1, 1,  6, 1, 0, 0, 0, 0, 2, 0)); // sub reissues
    mainVecs.push_back(mkVec(1,  1,  1, 1, 1,  2, 1, 0, 0, 0, 0, 0, 0)); // add r2
    mainVecs.push_back(mkVec(1,  1,  0, 1, 1,  2, 1, 0, 0, 0, 0, 0, 0)); // add r2 again
    mainVecs.push_back(mkVec(1,  2,  2, 1, 1,  8, 1, 0, 0, 0, 0, 1, 1)); // or r8,r2,r2
    mainVecs.push_back(mkVec(1,  1,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0)); // write r0
    mainVecs.push_back(mkVec(1,  0,  0, 1, 1,  9, 1, 0, 0, 0, 0, 0, 0)); // read r0,r0
    mainVecs.push_back(mkVec(1,  8,  2, 1, 1, 10, 1, 0, 0, 0, 0, 3, 0)); // r8 from oldest reg
    mainVecs.push_back(mkVec(1, 10,  9, 1, 1, 11, 0, 0, 0, 0, 0, 1, 2)); // store-like
    mainVecs.push_back(mkVec(1, 11, 10, 1, 1,  0, 0, 0, 0, 0, 0, 0, 2)); // non-writer ignored
    mainVecs.push_back(mkVec(1, 10, 10, 0, 1,  0, 0, 0, 0, 0, 0, 0, 3)); // rs not used
    mainVecs.push_back(mkVec(1,  1,  0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0)); // lw r12
    mainVecs.push_back(mkVec(1, 12,  1, 1, 1,  0, 0, 0, 1, 1, 0, 0, 0)); // beq stalls, no flush
    mainVecs.push_back(mkVec(1, 12,  1, 1, 1,  0, 0, 0, 1, 0, 1, 2, 0)); // beq issues, flush
    mainVecs.push_back(mkVec(1,  0,  0, 1, 0, 13, 1, 1, 0, 0, 0, 0, 0)); // lw r13
    mainVecs.push_back(mkVec(0, 13, 13, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0)); // invalid ID slot
    mainVecs.push_back(mkVec(1, 13, 13, 0, 1, 14, 1, 0, 0, 0, 0, 0, 2)); // r13 now forwardable
    mainVecs.push_back(mkVec(1, 14,  0, 1, 0, 15, 1, 1, 0, 0, 0, 1, 0)); // lw r15 uses r14
    mainVecs.push_back(mkVec(1, 15, 15, 1, 1, 16, 1, 0, 0, 1, 0, 0, 0)); // both operands stall
    mainVecs.push_back(mkVec(1, 15, 15, 1, 1, 16, 1, 0, 0, 0, 0, 2, 2));

    lat2Vecs.push_back(mkVec(1,  1,  0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 0)); // lw r5
    lat2Vecs.push_back(mkVec(1,  5,  0, 1, 1,  7, 1, 0, 0, 1, 0, 0, 0)); // add r7,r5,r0
    lat2Vecs.push_back(mkVec(1,  5,  0, 1, 1,  7, 1, 0, 0, 1, 0, 0, 0));
    lat2Vecs.push_back(mkVec(1,  5,  0, 1, 1,  7, 1, 0, 0, 0, 0, 3, 0));
    lat2Vecs.push_back(mkVec(1,  1,  0, 1, 0,  6, 1, 1, 0, 0, 0, 0, 0)); // lw r6
    lat2Vecs.push_back(mkVec(1,  0,  6, 0, 1,  8, 1, 0, 0, 1, 0, 0, 0));
    lat2Vecs.push_back(mkVec(1,  0,  6, 0, 1,  8, 1, 0, 0, 1, 0, 0, 0)); // counter saturates
    lat2Vecs.push_back(mkVec(1,  0,  6, 0, 1,  8, 1, 0, 0, 0, 0, 0, 3));

    resetN = 1'b0;
    doReset();
    checkOutput("reset.stall",  32'(stall1), 32'd0);
    checkOutput("reset.flush",  32'(flush1), 32'd0);
    checkOutput("reset.fwdA",   32'(fwdA1),  32'd0);
    checkOutput("reset.fwdB",   32'(fwdB1),  32'd0);
    checkOutput("reset.count1", count1,      32'd0);
    checkOutput("reset.count2", 32'(count2), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    dut2Sel = 1'b0;
    for (int i = 0; i < mainVecs.size(); i++) begin
      applyStimulus(mainVecs[i], $sformatf("main[%0d]", i));
      if (i == 4)  checkOutput("count.afterLoadUse", count1, 32'd1);
      if (i == 16) checkOutput("count.afterBranch",  count1, 32'd2);
      if (i == 22) checkOutput("count.afterDual",    count1, 32'd3);
    end

    // Reset in the middle of a load-use stall with a redirect pending.
    applyStimulus(mkVec(1, 1, 0, 1, 0, 20, 1, 1, 0, 0, 0, 0, 0), "rst.load");
    @(negedge clk);
    driveInputs(mkVec(1, 20, 1, 1, 1, 21, 1, 0, 1, 0, 0, 0, 0));
    #1;
    checkOutput("rst.preStall", 32'(stall1), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("rst.stallLow", 32'(stall1), 32'd0);
    checkOutput("rst.flushLow", 32'(flush1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst.fwdA",  32'(fwdA1), 32'd0);
    checkOutput("rst.fwdB",  32'(fwdB1), 32'd0);
    checkOutput("rst.count", count1,     32'd0);
    resetN = 1'b1;
    applyStimulus(mkVec(1, 20, 20, 1, 1, 22, 1, 0, 0, 0, 0, 0, 0), "rst.after");

    doReset();
    @(negedge clk);
    resetN  = 1'b1;
    dut2Sel = 1'b1;
    for (int i = 0; i < lat2Vecs.size(); i++) begin
      applyStimulus(lat2Vecs[i], $sformatf("lat2[%0d]", i));
      if (i == 3) checkOutput("lat2.count", 32'(count2), 32'd2);
    end
    checkOutput("lat2.countSat", 32'(count2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
